// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the programmable clock divider.
// Defaults give a 1 Hz output from the 25 MHz board clock. Half-periods are clamped to at least 1.
package clk_div_pkg;

  localparam int          DEF_CNT_W  = 25;
  localparam int unsigned DEF_HALF   = 12_500_000;
  localparam int          MAX_CH     = 8;
  localparam int          HALF_MAX_W = 32;

  // A half-period of 0 would make the wrap compare underflow, so 0 maps to 1.
  function automatic logic [HALF_MAX_W-1:0] half_clamp(input logic [HALF_MAX_W-1:0] half);
    return (half == '0) ? HALF_MAX_W'(1) : half;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: toggles clk_out every half_cur cycles and pulses tick on each toggle.
// Outputs are registered with one cycle of latency. ready stays low while a new half-period is pending.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int              CNT_W    = DEF_CNT_W,
  parameter logic [CNT_W-1:0] HALF_RST = CNT_W'(DEF_HALF)
) (
  input  logic             clock_25,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             load_acc,
  input  logic [CNT_W-1:0] load_half,
  output logic             ready,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_cur;
  logic [CNT_W-1:0] half_nxt;
  logic             pend;
  logic             wrap;
  logic             apply;

  // half_cur is never 0, so half_cur-1 cannot underflow.
  assign wrap  = (cnt == half_cur - CNT_W'(1));
  // Pending values land only where the phase restarts, so no output glitches.
  assign apply = pend && (sync || !en || wrap);
  assign ready = !pend;

  always_ff @(posedge clock_25) begin
    if (!reset) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      half_cur <= HALF_RST;
      half_nxt <= HALF_RST;
      pend     <= 1'b0;
    end else begin
      if (sync || !en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (wrap) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= 1'b1;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        tick    <= 1'b0;
      end

      if (apply) begin
        half_cur <= half_nxt;
        pend     <= 1'b0;
      end

      // Loads are only accepted when nothing is pending, so this never races apply.
      if (load_acc) begin
        half_nxt <= CNT_W'(half_clamp(HALF_MAX_W'(load_half)));
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider; CLKDIV_SYNC_START_EN adds a sync_start phase-align input.
// Registered outputs, one cycle latency. load_ready drops per channel while a reload is pending.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int          N_CH         = 2,
  parameter int          CNT_W        = DEF_CNT_W,
  parameter int unsigned DEFAULT_HALF = DEF_HALF,
  localparam int         CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock_25,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             load_valid,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0] load_half,
`ifdef CLKDIV_SYNC_START_EN
  input  logic             sync_start,
`endif
  output logic             load_ready,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  localparam logic [CNT_W-1:0] HALF_RST =
    (DEFAULT_HALF == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

  logic [N_CH-1:0] ready;
  logic [N_CH-1:0] load_acc;
  logic            sync;

`ifdef CLKDIV_SYNC_START_EN
  assign sync = sync_start;
`else
  assign sync = 1'b0;
`endif

  // Out-of-range channel indices match no channel, so they are never ready.
  always_comb begin
    load_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(load_ch) == i) load_ready = ready[i];
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign load_acc[i] = load_valid && load_ready && (int'(load_ch) == i);

    clk_div_chan #(
      .CNT_W    (CNT_W),
      .HALF_RST (HALF_RST)
    ) u_chan (
      .clock_25  (clock_25),
      .reset     (reset),
      .en        (en[i]),
      .sync      (sync),
      .load_acc  (load_acc[i]),
      .load_half (load_half),
      .ready     (ready[i]),
      .clk_out   (clk_out[i]),
      .tick      (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with N_CH=2, CNT_W=8, DEFAULT_HALF=4.
module tb_clk_div_prog;

  logic       clock_25 = 1'b0;
  logic       reset;
  logic [1:0] en;
  logic       load_valid;
  logic [0:0] load_ch;
  logic [7:0] load_half;
  logic       sync_start;
  logic       load_ready;
  logic [1:0] clk_out;
  logic [1:0] tick;

  int tests  = 0;
  int failed = 0;

  clk_div_prog #(.N_CH(2), .CNT_W(8), .DEFAULT_HALF(4)) dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .en         (en),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_half  (load_half),
`ifdef CLKDIV_SYNC_START_EN
    .sync_start (sync_start),
`endif
    .load_ready (load_ready),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #5 clock_25 = ~clock_25;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock_25);
    #1;
  endtask

  // Steps until tick[ch] is seen; returns cycles taken, or -1 if the budget expires.
  task automatic wait_tick(input int ch, output int cycles);
    cycles = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (tick[ch]) begin
        cycles = n;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 2'b11; load_valid = 1'b0; load_ch = 1'b0; load_half = 8'd0; sync_start = 1'b0;
    step(); step();
    tests++; if (clk_out !== 2'b00) begin failed++; $display("FAIL reset_clk_out: got %b want 00", clk_out); end
    tests++; if (tick !== 2'b00) begin failed++; $display("FAIL reset_tick: got %b want 00", tick); end
    tests++; if (load_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b want 1", load_ready); end
  endtask

  task automatic test_basic();
    int c;
    reset = 1'b1;
    wait_tick(0, c);
    tests++; if (c !== 4) begin failed++; $display("FAIL basic_first_toggle: got %0d want 4", c); end
    tests++; if (clk_out !== 2'b11) begin failed++; $display("FAIL basic_clk_high: got %b want 11", clk_out); end
    step();
    tests++; if (tick !== 2'b00) begin failed++; $display("FAIL basic_tick_width: got %b want 00", tick); end
    wait_tick(0, c);
    tests++; if (c !== 3) begin failed++; $display("FAIL basic_second_toggle: got %0d want 3", c); end
    tests++; if (clk_out !== 2'b00) begin failed++; $display("FAIL basic_clk_low: got %b want 00", clk_out); end
  endtask

  task automatic test_wrap_load();
    int c;
    step(); step(); step();
    load_valid = 1'b1; load_ch = 1'b0; load_half = 8'd2;
    step();
    tests++; if (tick[0] !== 1'b1) begin failed++; $display("FAIL wrapload_tick: got %b want 1", tick[0]); end
    tests++; if (load_ready !== 1'b0) begin failed++; $display("FAIL wrapload_stall: got %b want 0", load_ready); end
    load_half = 8'd6;
    wait_tick(0, c);
    tests++; if (c !== 4) begin failed++; $display("FAIL wrapload_old_half: got %0d want 4", c); end
    tests++; if (load_ready !== 1'b1) begin failed++; $display("FAIL wrapload_ready_again: got %b want 1", load_ready); end
    step();
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin failed++; $display("FAIL wrapload_second_pend: got %b want 0", load_ready); end
    wait_tick(0, c);
    tests++; if (c !== 1) begin failed++; $display("FAIL wrapload_half2: got %0d want 1", c); end
    wait_tick(0, c);
    tests++; if (c !== 6) begin failed++; $display("FAIL wrapload_half6: got %0d want 6", c); end
  endtask

  task automatic test_load_mid();
    int c;
    step(); step();
    load_valid = 1'b1; load_ch = 1'b0; load_half = 8'd2;
    tests++; if (load_ready !== 1'b1) begin failed++; $display("FAIL mid_ready_before: got %b want 1", load_ready); end
    step();
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin failed++; $display("FAIL mid_ready_pend: got %b want 0", load_ready); end
    wait_tick(0, c);
    tests++; if (c !== 3) begin failed++; $display("FAIL mid_finish_old: got %0d want 3", c); end
    tests++; if (load_ready !== 1'b1) begin failed++; $display("FAIL mid_ready_applied: got %b want 1", load_ready); end
    wait_tick(0, c);
    tests++; if (c !== 2) begin failed++; $display("FAIL mid_new_half_a: got %0d want 2", c); end
    wait_tick(0, c);
    tests++; if (c !== 2) begin failed++; $display("FAIL mid_new_half_b: got %0d want 2", c); end
  endtask

  task automatic test_clamp();
    int c;
    logic exp_clk;
    load_valid = 1'b1; load_ch = 1'b1; load_half = 8'd0;
    step();
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin failed++; $display("FAIL clamp_ch1_pend: got %b want 0", load_ready); end
    load_ch = 1'b0;
    #1;
    tests++; if (load_ready !== 1'b1) begin failed++; $display("FAIL clamp_ch0_free: got %b want 1", load_ready); end
    wait_tick(1, c);
    tests++; if (c !== 1) begin failed++; $display("FAIL clamp_last_wrap: got %0d want 1", c); end
    tests++; if (clk_out[1] !== 1'b1) begin failed++; $display("FAIL clamp_clk_phase: got %b want 1", clk_out[1]); end
    exp_clk = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_clk = ~exp_clk;
      tests++; if (tick[1] !== 1'b1 || clk_out[1] !== exp_clk)
        begin failed++; $display("FAIL clamp_fast_%0d: got tick=%b clk=%b want tick=1 clk=%b", k, tick[1], clk_out[1], exp_clk); end
    end
  endtask

  task automatic test_disable();
    int c;
    step();
    en = 2'b10;
    step();
    tests++; if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0)
      begin failed++; $display("FAIL dis_outputs: got clk=%b tick=%b want 0 0", clk_out[0], tick[0]); end
    tests++; if (tick[1] !== 1'b1) begin failed++; $display("FAIL dis_ch1_running: got %b want 1", tick[1]); end
    step();
    load_valid = 1'b1; load_ch = 1'b0; load_half = 8'd3;
    step();
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin failed++; $display("FAIL dis_load_pend: got %b want 0", load_ready); end
    step();
    tests++; if (load_ready !== 1'b1) begin failed++; $display("FAIL dis_load_applied: got %b want 1", load_ready); end
    en = 2'b11;
    wait_tick(0, c);
    tests++; if (c !== 3) begin failed++; $display("FAIL dis_reenable: got %0d want 3", c); end
    tests++; if (clk_out[0] !== 1'b1) begin failed++; $display("FAIL dis_reenable_clk: got %b want 1", clk_out[0]); end
  endtask

  task automatic test_reset_mid();
    int c;
    load_valid = 1'b1; load_ch = 1'b0; load_half = 8'd7;
    step();
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin failed++; $display("FAIL rstmid_pend: got %b want 0", load_ready); end
    reset = 1'b0;
    step();
    tests++; if (clk_out !== 2'b00 || tick !== 2'b00)
      begin failed++; $display("FAIL rstmid_outputs: got clk=%b tick=%b want 00 00", clk_out, tick); end
    tests++; if (load_ready !== 1'b1) begin failed++; $display("FAIL rstmid_pend_clear: got %b want 1", load_ready); end
    reset = 1'b1;
    wait_tick(0, c);
    tests++; if (c !== 4) begin failed++; $display("FAIL rstmid_half_a: got %0d want 4", c); end
    tests++; if (tick[1] !== 1'b1) begin failed++; $display("FAIL rstmid_ch1_aligned: got %b want 1", tick[1]); end
    wait_tick(0, c);
    tests++; if (c !== 4) begin failed++; $display("FAIL rstmid_half_b: got %0d want 4", c); end
  endtask

`ifdef CLKDIV_SYNC_START_EN
  task automatic test_sync_start();
    int c;
    en = 2'b01;
    step();
    en = 2'b11;
    step(); step();
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    tests++; if (clk_out !== 2'b00) begin failed++; $display("FAIL sync_clear: got %b want 00", clk_out); end
    wait_tick(0, c);
    tests++; if (c !== 4) begin failed++; $display("FAIL sync_first: got %0d want 4", c); end
    tests++; if (tick !== 2'b11) begin failed++; $display("FAIL sync_aligned: got %b want 11", tick); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap_load();
    test_load_mid();
    test_clamp();
    test_disable();
    test_reset_mid();
`ifdef CLKDIV_SYNC_START_EN
    test_sync_start();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
